regfile_burst_master: RTL and testbench

//  Initiator for the 8x32 register file: turns one command (op, base address, beat count)

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/regfile_rd_stage.sv | 49 ++++
 rtl/regfile_burst_master.sv | 160 ++++++++++++++++
 tb/tb_regfile_burst_master.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the 8x32 register file and its burst master:
//   - default data/address widths (must match Register_file)
//   - command opcode encodings (OP_WRITE / OP_READ)
//   - burst-master FSM state encoding
//   - clamp_beats(): limits a requested beat count to the register count
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 3;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A burst never touches more registers than exist; longer requests are
  // clamped to one full pass over the file.
  function automatic int unsigned clamp_beats(input int unsigned len,
                                              input int unsigned addr_w);
    int unsigned max_beats;
    max_beats = 32'd1 << addr_w;
    return (len > max_beats) ? max_beats : len;
  endfunction

endpackage

// File: rtl/regfile_rd_stage.sv
// ---------------------------------------------------------------------------
// regfile_rd_stage
// One-entry valid/ready output register for read beats (data + last flag).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load_i          : capture data_i/last_i this edge (caller only loads when
//                     the entry is empty or being drained this same edge)
//   data_i, last_i  : beat to capture
//   ready_i         : downstream consumes the held beat when valid_o&ready_i
//   valid_o, data_o, last_o : held beat
// ---------------------------------------------------------------------------
module regfile_rd_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      // Drained with nothing behind it: data/last keep their old value.
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/regfile_burst_master.sv
// ---------------------------------------------------------------------------
// regfile_burst_master
// Turns one command (op, base address, beat count) into a burst of register
// file writes or reads.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/
//   cmd_addr/cmd_len                : command channel (op 0 = write, 1 = read)
//   wr_valid/wr_ready/wr_data       : write-data stream into the file
//   rd_valid/rd_ready/rd_data/rd_last : read-data stream out of the file
//   busy, done                      : status (busy in every non-IDLE state,
//                                     done pulses one cycle per burst)
//   rf_we/rf_wAddr/rf_wData         : register-file write port
//   rf_rAddr/rf_rData               : register-file read port (combinational)
// ---------------------------------------------------------------------------
module regfile_burst_master
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wData,
  output logic [ADDR_W-1:0] rf_rAddr,
  input  logic [DATA_W-1:0] rf_rData
);

  state_e            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [LEN_W-1:0]  issue_left_q;   // read beats not yet captured (or writes left)
  logic [LEN_W-1:0]  accept_left_q;  // beats not yet handed over downstream
  logic              busy_q;
  logic              done_q;

  logic [LEN_W-1:0]  len_clamped;
  logic              cmd_fire;
  logic              wr_fire;
  logic              rd_load;
  logic              rd_fire;

  assign len_clamped = LEN_W'(clamp_beats(32'(cmd_len), ADDR_W));

  // NOTE: handshake readies are gated by reset combinationally, so no command
  // or write beat can complete on an edge where reset is sampled high.
  assign cmd_ready = (state_q == ST_IDLE)  && !reset;
  assign wr_ready  = (state_q == ST_WRITE) && !reset;
  assign rf_we     = wr_ready && wr_valid;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = rf_we;
  assign rf_wAddr  = cur_addr_q;
  assign rf_wData  = wr_data;
  assign rf_rAddr  = cur_addr_q;

  // Capture the next read beat whenever the output entry is free or is being
  // drained this edge; this sustains one beat per cycle with rd_ready high.
  assign rd_load = (state_q == ST_READ) && (issue_left_q != '0) &&
                   (!rd_valid || rd_ready);
  assign rd_fire = rd_valid && rd_ready;

  // NOTE: all state below is sequential and assigned with <= only, so every
  // branch reads the pre-edge register values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      issue_left_q  <= '0;
      accept_left_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            cur_addr_q    <= cmd_addr;
            issue_left_q  <= len_clamped;
            accept_left_q <= len_clamped;
            busy_q        <= 1'b1;
            if (len_clamped == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (cmd_op == OP_WRITE) begin
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end

        ST_WRITE: begin
          if (wr_fire) begin
            cur_addr_q    <= cur_addr_q + ADDR_W'(1);
            issue_left_q  <= issue_left_q - LEN_W'(1);
            accept_left_q <= accept_left_q - LEN_W'(1);
            if (accept_left_q == LEN_W'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        ST_READ: begin
          if (rd_load) begin
            cur_addr_q   <= cur_addr_q + ADDR_W'(1);
            issue_left_q <= issue_left_q - LEN_W'(1);
          end
          if (rd_fire) begin
            accept_left_q <= accept_left_q - LEN_W'(1);
            if (accept_left_q == LEN_W'(1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  regfile_rd_stage #(
    .DATA_W (DATA_W)
  ) u_rd_stage (
    .clk     (clk),
    .reset   (reset),
    .load_i  (rd_load),
    .data_i  (rf_rData),
    .last_i  (issue_left_q == LEN_W'(1)),
    .ready_i (rd_ready),
    .valid_o (rd_valid),
    .data_o  (rd_data),
    .last_o  (rd_last)
  );

endmodule

// File: tb/tb_regfile_burst_master.sv
// ---------------------------------------------------------------------------
// tb_regfile_burst_master
// Drives regfile_burst_master against a behavioural 8x32 register file and
// checks every cycle of each burst against a shadow copy of the file that the
// bench maintains from the data it sends.
// ---------------------------------------------------------------------------
module tb_regfile_burst_master;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int LEN_W  = 4;
  localparam int NREG   = 8;
  localparam int BUDGET = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              done;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wAddr;
  logic [DATA_W-1:0] rf_wData;
  logic [ADDR_W-1:0] rf_rAddr;
  logic [DATA_W-1:0] rf_rData;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_burst_master #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done),
    .rf_we     (rf_we),
    .rf_wAddr  (rf_wAddr),
    .rf_wData  (rf_wData),
    .rf_rAddr  (rf_rAddr),
    .rf_rData  (rf_rData)
  );

  // Behavioural register file: write at the edge, combinational read.
  logic [DATA_W-1:0] rf_mem [NREG];
  always @(posedge clk) if (rf_we) rf_mem[rf_wAddr] <= rf_wData;
  assign rf_rData = rf_mem[rf_rAddr];

  // Reference contents, updated only from what the bench intends to write.
  logic [DATA_W-1:0] ref_mem [NREG];

  function automatic int beats_of(input int len);
    return (len > NREG) ? NREG : len;
  endfunction

  // Offer a command at the current (post-negedge) phase; it must be accepted.
  task automatic issue_cmd(input logic op, input int base, input int len,
                           input string name);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = ADDR_W'(base);
    cmd_len   = LEN_W'(len);
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Cycle after the final beat: one done cycle, then idle with cmd_ready.
  task automatic check_done_then_idle(input string name);
    logic [4:0] got;
    cmd_valid = 1'b0;
    wr_valid  = 1'b0;
    #1;
    got = {done, busy, cmd_ready, rf_we, rd_valid};
    tests_run++;
    if (got !== 5'b11000) begin
      tests_failed++;
      $display("FAIL %s done_cycle {done,busy,cmd_ready,rf_we,rd_valid}: got %b want 11000", name, got);
    end
    @(negedge clk);
    #1;
    got = {done, busy, cmd_ready, rf_we, rd_valid};
    tests_run++;
    if (got !== 5'b00100) begin
      tests_failed++;
      $display("FAIL %s idle_after {done,busy,cmd_ready,rf_we,rd_valid}: got %b want 00100", name, got);
    end
  endtask

  // gap_mode: 0 = wr_valid always high, 1 = high/low alternating, 2 = random.
  task automatic write_burst(input int base, input int len, input int gap_mode,
                             input bit rand_data, input logic [DATA_W-1:0] data_base,
                             input string name);
    int n, i, cycles, addr;
    bit phase;
    logic [DATA_W-1:0] d;
    logic [39:0] got, exp;
    n = beats_of(len);
    i = 0;
    cycles = 0;
    phase = 1'b1;
    issue_cmd(1'b0, base, len, name);
    while (i < n && cycles < BUDGET) begin
      case (gap_mode)
        0:       wr_valid = 1'b1;
        1:       wr_valid = phase;
        default: wr_valid = 1'($urandom_range(0, 1));
      endcase
      phase = !phase;
      d = rand_data ? DATA_W'($urandom) : data_base + DATA_W'(i);
      wr_data = d;
      // Commands offered mid-burst must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 1'($urandom_range(0, 1));
      cmd_len   = LEN_W'($urandom_range(0, 15));
      addr = (base + i) % NREG;
      #1;
      got = {wr_ready, rf_we, rf_wAddr, rf_wData, cmd_ready, busy, done};
      exp = {1'b1, wr_valid, ADDR_W'(addr), d, 1'b0, 1'b1, 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL %s beat%0d {wr_ready,we,addr,data,cmd_ready,busy,done}: got %h want %h",
                 name, i, got, exp);
      end
      if (wr_valid) begin
        ref_mem[addr] = d;
        i++;
      end
      @(negedge clk);
      cycles++;
    end
    tests_run++;
    if (i != n) begin
      tests_failed++;
      $display("FAIL %s timeout: wrote %0d beats, want %0d", name, i, n);
    end
    check_done_then_idle(name);
  endtask

  // stall_mode: 0 = rd_ready always high, 1 = toggling 1,0, 2 = random.
  task automatic read_burst(input int base, input int len, input int stall_mode,
                            input string name);
    int n, k, cycles;
    bit phase;
    logic [DATA_W+5:0] got, exp;
    logic [4:0] g0;
    n = beats_of(len);
    k = 0;
    cycles = 0;
    phase = 1'b1;
    wr_valid = 1'b0;
    issue_cmd(1'b1, base, len, name);
    if (n > 0) begin
      // First cycle of the burst: address presented, no data yet.
      rd_ready = 1'b1;
      #1;
      g0 = {rd_valid, busy, cmd_ready, done, rf_we};
      tests_run++;
      if (g0 !== 5'b01000) begin
        tests_failed++;
        $display("FAIL %s first_cycle {rd_valid,busy,cmd_ready,done,rf_we}: got %b want 01000", name, g0);
      end
      @(negedge clk);
    end
    while (k < n && cycles < BUDGET) begin
      case (stall_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = phase;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      phase = !phase;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 1'($urandom_range(0, 1));
      #1;
      // From the first beat until the last is taken, rd_valid stays high.
      got = {rd_valid, rd_data, rd_last, cmd_ready, busy, done, rf_we};
      exp = {1'b1, ref_mem[(base + k) % NREG], (k == n - 1), 1'b0, 1'b1, 1'b0, 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL %s beat%0d {valid,data,last,cmd_ready,busy,done,we}: got %h want %h",
                 name, k, got, exp);
      end
      if (rd_ready) k++;
      @(negedge clk);
      cycles++;
    end
    tests_run++;
    if (k != n) begin
      tests_failed++;
      $display("FAIL %s timeout: read %0d beats, want %0d", name, k, n);
    end
    rd_ready = 1'b0;
    check_done_then_idle(name);
  endtask

  task automatic test_reset();
    logic [38:0] got;
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = 4'd3;
    wr_valid  = 1'b1;
    wr_data   = '1;
    rd_ready  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      got = {cmd_ready, wr_ready, rf_we, rd_valid, rd_last, rd_data, busy, done};
      tests_run++;
      if (got !== '0) begin
        tests_failed++;
        $display("FAIL reset_state {cmd_ready,wr_ready,we,rd_valid,rd_last,rd_data,busy,done}: got %h want 0", got);
      end
    end
    @(negedge clk);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    #1;
    tests_run++;
    if ({cmd_ready, busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_release {cmd_ready,busy}: got %b want 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_write_basic();
    write_burst(1, 7, 0, 1'b0, 32'h1, "write_basic");
  endtask

  task automatic test_read_basic();
    read_burst(1, 7, 0, "read_basic");
  endtask

  task automatic test_wrap();
    write_burst(6, 4, 0, 1'b0, 32'hA, "wrap_write");
    read_burst(6, 4, 0, "wrap_read");
    // Over-long bursts are clamped to one pass over the file.
    write_burst(3, 12, 0, 1'b1, '0, "clamp_write");
    read_burst(3, 15, 0, "clamp_read");
  endtask

  task automatic test_read_stall();
    write_burst(1, 7, 0, 1'b0, 32'h1, "stall_prep");
    read_burst(1, 7, 1, "read_stall");
  endtask

  task automatic test_write_gaps_and_zero_len();
    write_burst(0, 7, 1, 1'b1, '0, "write_gaps");
    write_burst(2, 0, 0, 1'b0, '0, "write_len0");
    read_burst(5, 0, 0, "read_len0");
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] g;
    // Read aborted after its third beat.
    read_burst(1, 7, 0, "pre_abort");
    issue_cmd(1'b1, 1, 7, "abort_rd_cmd");
    rd_ready = 1'b1;
    @(negedge clk);   // first cycle: no data yet
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if ({rd_valid, rd_data} !== {1'b1, ref_mem[(1 + k) % NREG]}) begin
        tests_failed++;
        $display("FAIL abort_rd beat%0d {valid,data}: got %h want %h", k,
                 {rd_valid, rd_data}, {1'b1, ref_mem[(1 + k) % NREG]});
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({cmd_ready, wr_ready, rf_we} !== 3'b000) begin
      tests_failed++;
      $display("FAIL abort_rd gating {cmd_ready,wr_ready,we}: got %b want 000", {cmd_ready, wr_ready, rf_we});
    end
    @(negedge clk);
    #1;
    g = {rd_valid, busy, done, cmd_ready};
    tests_run++;
    if (g !== 4'b0000) begin
      tests_failed++;
      $display("FAIL abort_rd after_reset {rd_valid,busy,done,cmd_ready}: got %b want 0000", g);
    end
    reset    = 1'b0;
    rd_ready = 1'b0;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_rd release cmd_ready: got %b want 1", cmd_ready);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      tests_run++;
      if ({done, busy, rd_valid} !== 3'b000) begin
        tests_failed++;
        $display("FAIL abort_rd quiet {done,busy,rd_valid}: got %b want 000", {done, busy, rd_valid});
      end
    end

    // Write aborted after two beats: the beat offered during reset is dropped.
    issue_cmd(1'b0, 0, 5, "abort_wr_cmd");
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'h100 + DATA_W'(i);
      ref_mem[i] = wr_data;
      @(negedge clk);
    end
    reset   = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if ({wr_ready, rf_we} !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort_wr gating {wr_ready,we}: got %b want 00", {wr_ready, rf_we});
    end
    @(negedge clk);
    reset    = 1'b0;
    wr_valid = 1'b0;
    #1;
    tests_run++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      tests_failed++;
      $display("FAIL abort_wr release {cmd_ready,busy,done}: got %b want 100", {cmd_ready, busy, done});
    end
    // Only the two accepted beats may have landed.
    read_burst(0, 3, 0, "abort_wr_check");
  endtask

  task automatic test_random();
    int base, len;
    for (int t = 0; t < 24; t++) begin
      base = $urandom_range(0, NREG - 1);
      len  = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) write_burst(base, len, 2, 1'b1, '0, "rand_write");
      else                           read_burst(base, len, 2, "rand_read");
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_read_stall();
    test_write_gaps_and_zero_len();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
